voice_allocator: RTL

Note-event scheduler that sits in front of `channel_mixer` and drives its `pitches`, `channel_ena` and `waveforms` buses. It accepts note-on and note-off events over a valid/ready handshake and assigns each note to a free channel. When every channel is busy, it steals the oldest channel. A channel is released when its key receives a note-off. The block serialises events and runs a per-channel scan state machine, so one event is processed at a time.

---
 rtl/voice_allocator_if.sv | 24 ++
 rtl/voice_allocator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator_if.sv
// Note-event handshake between a note source and the voice allocator.
// The source (master) presents one event under note_valid. The allocator
// (slave) takes the event in a cycle where note_ready is also high.
interface voice_allocator_if #(
   parameter int C = 14,
   parameter int K = 7
);
   logic         note_valid;
   logic         note_ready;
   logic         note_on;
   logic [K-1:0] note_key;
   logic [C-1:0] note_pitch;
   logic [1:0]   note_waveform;

   modport master (
      output note_valid, note_on, note_key, note_pitch, note_waveform,
      input  note_ready
   );

   modport slave (
      input  note_valid, note_on, note_key, note_pitch, note_waveform,
      output note_ready
   );
endinterface

// File: rtl/voice_allocator.sv
// Voice allocator placed in front of channel_mixer.
// Events are handled one at a time. An accepted event is scanned across
// all channels, one channel per cycle, to find three candidates: a matching
// key, a free channel and the oldest channel. The event is then applied in
// a single cycle. The all_off input clears every channel and drops any
// event that is in flight.
module voice_allocator #(
   parameter int NUM = 4,
   parameter int C   = 14,
   parameter int K   = 7,
   parameter int AW  = 4
) (
   input  logic                clk,
   input  logic                rst,
   voice_allocator_if.slave    note,
   input  logic                all_off,
   output logic [NUM*C-1:0]    pitches,
   output logic [NUM*2-1:0]    waveforms,
   output logic [NUM-1:0]      channel_ena,
   output logic                voice_stolen
);
   localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;
   localparam logic [AW-1:0] AGE_MAX = {AW{1'b1}};

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_APPLY} state_t;

   state_t         state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;

   // latched event
   logic           lat_on_q, lat_on_d;
   logic [K-1:0]   lat_key_q, lat_key_d;
   logic [C-1:0]   lat_pitch_q, lat_pitch_d;
   logic [1:0]     lat_wave_q, lat_wave_d;

   // scan candidates
   logic           match_vld_q, match_vld_d;
   logic [IW-1:0]  match_idx_q, match_idx_d;
   logic           free_vld_q, free_vld_d;
   logic [IW-1:0]  free_idx_q, free_idx_d;
   logic           old_vld_q, old_vld_d;
   logic [IW-1:0]  old_idx_q, old_idx_d;
   logic [AW-1:0]  old_age_q, old_age_d;

   // per-channel state
   logic [K-1:0]   key_q   [NUM];
   logic [K-1:0]   key_d   [NUM];
   logic [AW-1:0]  age_q   [NUM];
   logic [AW-1:0]  age_d   [NUM];
   logic [C-1:0]   pitch_q [NUM];
   logic [C-1:0]   pitch_d [NUM];
   logic [1:0]     wave_q  [NUM];
   logic [1:0]     wave_d  [NUM];
   logic [NUM-1:0] ena_q, ena_d;
   logic           stolen_q, stolen_d;

   logic [IW-1:0]  sel;

   // Ready is a function of state and reset only. It is never a function of note_valid.
   assign note.note_ready = (state_q == S_IDLE) && !rst;

   // Next-state logic: accept, then scan, then apply. all_off overrides everything else.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      lat_on_d    = lat_on_q;
      lat_key_d   = lat_key_q;
      lat_pitch_d = lat_pitch_q;
      lat_wave_d  = lat_wave_q;
      match_vld_d = match_vld_q;
      match_idx_d = match_idx_q;
      free_vld_d  = free_vld_q;
      free_idx_d  = free_idx_q;
      old_vld_d   = old_vld_q;
      old_idx_d   = old_idx_q;
      old_age_d   = old_age_q;
      ena_d       = ena_q;
      stolen_d    = 1'b0;
      sel         = '0;
      for (int i = 0; i < NUM; i++) begin
         key_d[i]   = key_q[i];
         age_d[i]   = age_q[i];
         pitch_d[i] = pitch_q[i];
         wave_d[i]  = wave_q[i];
      end

      case (state_q)
         S_IDLE: begin
            if (note.note_valid) begin
               lat_on_d    = note.note_on;
               lat_key_d   = note.note_key;
               lat_pitch_d = note.note_pitch;
               lat_wave_d  = note.note_waveform;
               idx_d       = '0;
               match_vld_d = 1'b0;
               free_vld_d  = 1'b0;
               old_vld_d   = 1'b0;
               state_d     = S_SCAN;
            end
         end
         S_SCAN: begin
            // Only disabled channels can be free. Disabled channels never match.
            if (ena_q[idx_q] && key_q[idx_q] == lat_key_q && !match_vld_q) begin
               match_vld_d = 1'b1;
               match_idx_d = idx_q;
            end
            if (!ena_q[idx_q] && !free_vld_q) begin
               free_vld_d = 1'b1;
               free_idx_d = idx_q;
            end
            // A strict compare keeps the lowest index when ages are equal.
            if (ena_q[idx_q] && (!old_vld_q || age_q[idx_q] > old_age_q)) begin
               old_vld_d = 1'b1;
               old_idx_d = idx_q;
               old_age_d = age_q[idx_q];
            end
            if (idx_q == IW'(NUM - 1)) begin
               state_d = S_APPLY;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         S_APPLY: begin
            if (lat_on_q) begin
               sel = match_vld_q ? match_idx_q : (free_vld_q ? free_idx_q : old_idx_q);
               for (int i = 0; i < NUM; i++) begin
                  if (i == int'(sel)) begin
                     key_d[i]   = lat_key_q;
                     pitch_d[i] = lat_pitch_q;
                     wave_d[i]  = lat_wave_q;
                     age_d[i]   = '0;
                     ena_d[i]   = 1'b1;
                  end else if (ena_q[i] && age_q[i] != AGE_MAX) begin
                     age_d[i] = age_q[i] + AW'(1);
                  end
               end
               stolen_d = !match_vld_q && !free_vld_q;
            end else if (match_vld_q) begin
               ena_d[match_idx_q] = 1'b0;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (all_off) begin
         ena_d    = '0;
         stolen_d = 1'b0;
         state_d  = S_IDLE;
         for (int i = 0; i < NUM; i++) begin
            age_d[i] = '0;
         end
      end
   end

   // State and channel registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         lat_on_q    <= 1'b0;
         lat_key_q   <= '0;
         lat_pitch_q <= '0;
         lat_wave_q  <= '0;
         match_vld_q <= 1'b0;
         match_idx_q <= '0;
         free_vld_q  <= 1'b0;
         free_idx_q  <= '0;
         old_vld_q   <= 1'b0;
         old_idx_q   <= '0;
         old_age_q   <= '0;
         ena_q       <= '0;
         stolen_q    <= 1'b0;
         for (int i = 0; i < NUM; i++) begin
            key_q[i]   <= '0;
            age_q[i]   <= '0;
            pitch_q[i] <= '0;
            wave_q[i]  <= '0;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         lat_on_q    <= lat_on_d;
         lat_key_q   <= lat_key_d;
         lat_pitch_q <= lat_pitch_d;
         lat_wave_q  <= lat_wave_d;
         match_vld_q <= match_vld_d;
         match_idx_q <= match_idx_d;
         free_vld_q  <= free_vld_d;
         free_idx_q  <= free_idx_d;
         old_vld_q   <= old_vld_d;
         old_idx_q   <= old_idx_d;
         old_age_q   <= old_age_d;
         ena_q       <= ena_d;
         stolen_q    <= stolen_d;
         for (int i = 0; i < NUM; i++) begin
            key_q[i]   <= key_d[i];
            age_q[i]   <= age_d[i];
            pitch_q[i] <= pitch_d[i];
            wave_q[i]  <= wave_d[i];
         end
      end
   end

   assign channel_ena  = ena_q;
   assign voice_stolen = stolen_q;

   for (genvar gi = 0; gi < NUM; gi++) begin : g_out
      assign pitches[C*gi +: C]   = pitch_q[gi];
      assign waveforms[2*gi +: 2] = wave_q[gi];
   end
endmodule
